// File: rtl/gem_copad_trigger.sv
// GEM co-pad self-trigger.
// Accumulates the FEB list of co-pad matches over a programmable window,
// issues a prescaled one-bx trigger pulse, then enforces a dead time.
// Also keeps saturating counters of matched clusters, issued triggers and
// prescaler-suppressed decisions.
module gem_copad_trigger #(
  parameter int MXFEB             = 24,
  parameter int MXCLUSTER_CHAMBER = 8,
  parameter int MXCNTB            = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [MXCLUSTER_CHAMBER-1:0] match,
  input  logic                         any_match,
  input  logic [MXFEB-1:0]             active_feb_list,
  input  logic                         trig_enable,
  input  logic [2:0]                   window,
  input  logic [3:0]                   deadtime,
  input  logic [3:0]                   prescale,
  input  logic                         cnt_reset,
  output logic                         gem_trig,
  output logic [MXFEB-1:0]             trig_feb_list,
  output logic                         busy,
  output logic [MXCNTB-1:0]            copad_cnt,
  output logic [MXCNTB-1:0]            trig_cnt,
  output logic [MXCNTB-1:0]            presc_cnt
);

  // Counter sums are formed 4 bits wider than the counters so the
  // overflow is visible before clamping.
  localparam int SUMW = MXCNTB + 4;

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, DEAD} state_t;

  state_t           state;
  logic [MXFEB-1:0] acc_list;
  logic [2:0]       wcnt;
  logic [2:0]       win_s;
  logic [3:0]       dcnt;
  logic [3:0]       pcnt;
  logic             fire_hit;
  logic             fire_miss;

  function automatic logic [SUMW-1:0] popcount(input logic [MXCLUSTER_CHAMBER-1:0] v);
    logic [SUMW-1:0] n;
    n = '0;
    for (int i = 0; i < MXCLUSTER_CHAMBER; i++) begin
      n = n + SUMW'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [MXCNTB-1:0] sat_add(input logic [MXCNTB-1:0] a,
                                                input logic [SUMW-1:0]   b);
    logic [SUMW-1:0] s;
    s = {4'b0000, a} + b;
    if (s > {4'b0000, {MXCNTB{1'b1}}}) begin
      return {MXCNTB{1'b1}};
    end
    return s[MXCNTB-1:0];
  endfunction

  // Prescale decision, only meaningful while in FIRE. The >= keeps the
  // prescaler from stalling if prescale is lowered below the current pcnt.
  assign fire_hit  = (state == FIRE) && (pcnt >= prescale);
  assign fire_miss = (state == FIRE) && (pcnt <  prescale);

  // Trigger sequencer: IDLE -> ACCUM -> FIRE -> DEAD -> IDLE, registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      gem_trig      <= 1'b0;
      trig_feb_list <= '0;
      acc_list      <= '0;
      wcnt          <= '0;
      win_s         <= '0;
      dcnt          <= '0;
    end else begin
      gem_trig <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_enable && any_match) begin
            // This bx is window bx 0; a zero-length window fires next bx.
            acc_list <= active_feb_list;
            wcnt     <= '0;
            win_s    <= window;
            busy     <= 1'b1;
            state    <= (window == 3'd0) ? FIRE : ACCUM;
          end
        end
        ACCUM: begin
          acc_list <= acc_list | active_feb_list;
          wcnt     <= wcnt + 3'd1;
          if (({1'b0, wcnt} + 4'd1) >= {1'b0, win_s}) begin
            state <= FIRE;
          end
        end
        FIRE: begin
          trig_feb_list <= acc_list;
          gem_trig      <= fire_hit;
          if (deadtime != 4'd0) begin
            dcnt  <= deadtime;
            state <= DEAD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DEAD: begin
          dcnt <= dcnt - 4'd1;
          if (dcnt <= 4'd1) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Prescaler position plus trigger / suppressed-decision counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcnt      <= '0;
      trig_cnt  <= '0;
      presc_cnt <= '0;
    end else if (cnt_reset) begin
      pcnt      <= '0;
      trig_cnt  <= '0;
      presc_cnt <= '0;
    end else if (fire_hit) begin
      pcnt     <= '0;
      trig_cnt <= sat_add(trig_cnt, SUMW'(1));
    end else if (fire_miss) begin
      pcnt      <= pcnt + 4'd1;
      presc_cnt <= sat_add(presc_cnt, SUMW'(1));
    end
  end

  // Matched-cluster counter, runs in every state regardless of trig_enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      copad_cnt <= '0;
    end else if (cnt_reset) begin
      copad_cnt <= '0;
    end else begin
      copad_cnt <= sat_add(copad_cnt, popcount(match));
    end
  end

endmodule

// File: doc/gem_copad_trigger.md
GEM_COPAD_TRIGGER -- requirements
Module: gem_copad_trigger

Interface
REQ-001 Parameter MXFEB, 24, number of GEM front-end boards per chamber.
REQ-002 Parameter MXCLUSTER_CHAMBER, 8, number of cluster match flags per bx.
REQ-003 Parameter MXCNTB, 16, width of the status counters.
REQ-004 clock  in  1  40 MHz fabric clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 match  in  MXCLUSTER_CHAMBER  registered co-pad match flags, one per gemA cluster.
REQ-007 any_match  in  1  registered OR of match.
REQ-008 active_feb_list  in  MXFEB  registered FEBs holding a matched cluster this bx.
REQ-009 trig_enable  in  1  enables trigger generation.
REQ-010 window  in  3  accumulation length minus 1; the window spans window+1 bx.
REQ-011 deadtime  in  4  idle bx forced after each trigger decision.
REQ-012 prescale  in  4  issue 1 trigger per prescale+1 decisions.
REQ-013 cnt_reset  in  1  synchronous clear of all counters.
REQ-014 gem_trig  out  1  one-bx self-trigger pulse.
REQ-015 trig_feb_list  out  MXFEB  FEB list accumulated over the window, held until the next decision.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 copad_cnt  out  MXCNTB  saturating count of matched clusters.
REQ-018 trig_cnt  out  MXCNTB  saturating count of issued gem_trig pulses.
REQ-019 presc_cnt  out  MXCNTB  saturating count of decisions suppressed by the prescaler.

Function
REQ-020 The FSM shall have the states IDLE, ACCUM, FIRE and DEAD.
REQ-021 IDLE->ACCUM when trig_enable and any_match are both high; that bx counts as window bx 0, its active_feb_list loads acc_list, and wcnt loads 0.
REQ-022 ACCUM: acc_list ORs active_feb_list and wcnt increments each bx; ACCUM->FIRE on the bx after wcnt reaches window (window=0: FIRE on the bx after entry).
REQ-023 FIRE lasts exactly 1 bx: trig_feb_list<=acc_list, and the prescale decision is evaluated in this state.
REQ-024 Prescale: pcnt counts decisions; when pcnt==prescale, gem_trig asserts and pcnt<=0, otherwise pcnt increments and presc_cnt increments.
REQ-025 gem_trig is registered and high for exactly the 1 bx following FIRE; trig_cnt increments in that same bx.
REQ-026 FIRE->DEAD if deadtime!=0, with dcnt<=deadtime; otherwise FIRE->IDLE.
REQ-027 DEAD decrements dcnt each bx and goes to IDLE on the bx dcnt reaches 1; any_match in DEAD or FIRE is ignored for triggering.
REQ-028 Latency: any_match in IDLE at bx N produces gem_trig at bx N+window+2.
REQ-029 Deasserting trig_enable in ACCUM, FIRE or DEAD shall not abort the sequence; it only blocks the IDLE->ACCUM transition.
REQ-030 copad_cnt adds popcount(match) every bx in every state, independent of trig_enable; the add is performed at MXCNTB+4 width and clamped to all-ones.
REQ-031 trig_cnt and presc_cnt saturate at all-ones and never wrap.
REQ-032 cnt_reset clears copad_cnt, trig_cnt, presc_cnt and pcnt and takes priority over a same-bx increment; the FSM is unaffected.
REQ-033 prescale, window and deadtime are sampled on entry to the state that uses them; changes mid-sequence take effect on the next use.

Reset
REQ-034 On reset: state=IDLE, gem_trig=0, busy=0, trig_feb_list=0, acc_list=0, wcnt=dcnt=pcnt=0, and all counters =0.
REQ-035 Reset asserted mid-sequence returns the FSM to IDLE immediately; no gem_trig is issued for the interrupted window.

Verification
REQ-036 window=2, deadtime=0, prescale=0: any_match with feb list 0x000001 at bx 10, then 0x000100 at bx 11 -> gem_trig at bx 14 only, trig_feb_list=0x000101, trig_cnt=1.
REQ-037 deadtime=5, window=0, any_match held high continuously -> gem_trig pulses every 7 bx.
REQ-038 prescale=3, 8 isolated matches spaced beyond the deadtime -> 2 gem_trig, trig_cnt=2, presc_cnt=6.
REQ-039 match=0xFF for 8200 bx -> copad_cnt=0xFFFF saturated, no wrap; cnt_reset then gives copad_cnt=0 the following bx.
REQ-040 Reset pulsed during ACCUM -> busy=0 and no gem_trig; trig_enable=0 with any_match=1 -> FSM stays in IDLE while copad_cnt still counts.
